// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: round-robin arbiter of N line requesters onto one memory port.
// Define ARB_PERF_CNT_EN to add saturating grant and wait-cycle counters.
module mem_arbiter_n #(
   parameter int NUM_PORTS  = 2,
   parameter int LINE_WIDTH = 256,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_PORTS-1:0]           req_read,
   input  logic [NUM_PORTS-1:0]           req_write,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_PORTS*LINE_WIDTH-1:0] req_wdata,
   output logic [LINE_WIDTH-1:0]          req_rdata,
   output logic [NUM_PORTS-1:0]           req_resp,
   output logic                           pmem_read,
   output logic                           pmem_write,
   output logic [ADDR_WIDTH-1:0]          pmem_address,
   output logic [LINE_WIDTH-1:0]          pmem_wdata,
   input  logic [LINE_WIDTH-1:0]          pmem_rdata,
   input  logic                           pmem_resp,
   output logic [NUM_PORTS*32-1:0]        perf_grants,
   output logic [31:0]                    perf_wait_cycles
);

   localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]            state_q;
   logic [1:0]            state_d;
   logic [IDX_W-1:0]      rr_ptr_q;
   logic [IDX_W-1:0]      gnt_q;
   logic                  op_write_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LINE_WIDTH-1:0] wdata_q;

   logic [NUM_PORTS-1:0]   active;
   logic [2*NUM_PORTS-1:0] dbl;
   logic [NUM_PORTS-1:0]   rot;
   logic [IDX_W-1:0]       off;
   logic [IDX_W:0]         sum;
   logic [IDX_W-1:0]       sel_idx;
   logic                   sel_valid;
   logic [IDX_W-1:0]       rr_next;
   logic [NUM_PORTS-1:0]   gnt_oh;
   logic                   busy;
   logic                   grant;
   logic                   finish;

   logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
   logic [LINE_WIDTH-1:0] wdata_arr [NUM_PORTS];

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
      assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[g] = req_wdata[g*LINE_WIDTH +: LINE_WIDTH];
   end

   assign active = req_read | req_write;

   // rotate so bit 0 is rr_ptr, then take the lowest set offset
   assign dbl = {active, active} >> rr_ptr_q;
   assign rot = dbl[NUM_PORTS-1:0];

   always_comb begin
      off = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (rot[k]) begin
            off = IDX_W'(k);
         end
      end
   end

   assign sel_valid = |active;
   assign sum       = {1'b0, rr_ptr_q} + {1'b0, off};

   always_comb begin
      sel_idx = sum[IDX_W-1:0];
      if (sum >= (IDX_W+1)'(NUM_PORTS)) begin
         sel_idx = IDX_W'(sum - (IDX_W+1)'(NUM_PORTS));
      end
   end

   assign rr_next = (gnt_q == IDX_W'(NUM_PORTS - 1)) ? '0 : gnt_q + 1'b1;
   assign gnt_oh  = NUM_PORTS'(1) << gnt_q;

   assign busy   = (state_q == S_BUSY);
   assign grant  = (state_q == S_IDLE) && sel_valid;
   assign finish = busy && pmem_resp;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (sel_valid) state_d = S_BUSY;
         S_BUSY:  if (pmem_resp) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= '0;
         gnt_q      <= '0;
         op_write_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            gnt_q      <= sel_idx;
            op_write_q <= req_write[sel_idx];
            addr_q     <= addr_arr[sel_idx];
            wdata_q    <= wdata_arr[sel_idx];
         end
         if (finish) begin
            rr_ptr_q <= rr_next;
         end
      end
   end

   // a write wins over a simultaneous read from the same port
   assign pmem_read    = busy && !op_write_q;
   assign pmem_write   = busy && op_write_q;
   assign pmem_address = addr_q;
   assign pmem_wdata   = wdata_q;
   assign req_rdata    = pmem_rdata;
   assign req_resp     = finish ? gnt_oh : '0;

`ifdef ARB_PERF_CNT_EN
   logic [31:0]          grant_cnt_q [NUM_PORTS];
   logic [31:0]          wait_cnt_q;
   logic [NUM_PORTS-1:0] sel_oh;
   logic [NUM_PORTS-1:0] cur_oh;
   logic [NUM_PORTS-1:0] waiting;

   assign sel_oh  = NUM_PORTS'(1) << sel_idx;
   assign cur_oh  = busy ? gnt_oh : (grant ? sel_oh : '0);
   assign waiting = active & ~cur_oh;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt_q <= '0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            grant_cnt_q[i] <= '0;
         end
      end else begin
         if (|waiting && wait_cnt_q != 32'hFFFF_FFFF) begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
         end
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant && sel_idx == IDX_W'(i)
                && grant_cnt_q[i] != 32'hFFFF_FFFF) begin
               grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_perf
      assign perf_grants[g*32 +: 32] = grant_cnt_q[g];
   end
   assign perf_wait_cycles = wait_cnt_q;
`else
   assign perf_grants      = '0;
   assign perf_wait_cycles = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter_n.sv
// tb_mem_arbiter_n: directed and random checks of mem_arbiter_n
// against a transaction-level model of the arbitration rules.
module tb_mem_arbiter_n;

   localparam int N  = 4;
   localparam int LW = 64;
   localparam int AW = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_read;
   logic [N-1:0]    req_write;
   logic [N*AW-1:0] req_addr;
   logic [N*LW-1:0] req_wdata;
   logic [LW-1:0]   req_rdata;
   logic [N-1:0]    req_resp;
   logic            pmem_read;
   logic            pmem_write;
   logic [AW-1:0]   pmem_address;
   logic [LW-1:0]   pmem_wdata;
   logic [LW-1:0]   pmem_rdata;
   logic            pmem_resp;
   logic [N*32-1:0] perf_grants;
   logic [31:0]     perf_wait_cycles;

   int total = 0;
   int bad   = 0;

   // model: one outstanding transaction, a one-cycle gap, a rotating pointer
   bit              m_busy;
   bit              m_done;
   bit              m_wr;
   int              m_port;
   int              m_ptr;
   logic [AW-1:0]   m_addr;
   logic [LW-1:0]   m_wdata;
   longint unsigned m_gcnt [N];
   longint unsigned m_wait;

   mem_arbiter_n #(
      .NUM_PORTS (N),
      .LINE_WIDTH(LW),
      .ADDR_WIDTH(AW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .req_read        (req_read),
      .req_write       (req_write),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .req_rdata       (req_rdata),
      .req_resp        (req_resp),
      .pmem_read       (pmem_read),
      .pmem_write      (pmem_write),
      .pmem_address    (pmem_address),
      .pmem_wdata      (pmem_wdata),
      .pmem_rdata      (pmem_rdata),
      .pmem_resp       (pmem_resp),
      .perf_grants     (perf_grants),
      .perf_wait_cycles(perf_wait_cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick();
      for (int k = 0; k < N; k++) begin
         int p;
         p = (m_ptr + k) % N;
         if (req_read[p] || req_write[p]) return p;
      end
      return -1;
   endfunction

   function automatic longint unsigned sat(input longint unsigned v);
      return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
   endfunction

   task automatic model_reset();
      m_busy  = 0;
      m_done  = 0;
      m_wr    = 0;
      m_port  = 0;
      m_ptr   = 0;
      m_addr  = '0;
      m_wdata = '0;
      m_wait  = 0;
      for (int i = 0; i < N; i++) m_gcnt[i] = 0;
   endtask

   task automatic check_outputs();
      logic [N-1:0] exp_resp;
      exp_resp = (m_busy && pmem_resp) ? N'(1) << m_port : '0;
      chk("pmem_read", 64'(pmem_read), 64'(m_busy && !m_wr));
      chk("pmem_write", 64'(pmem_write), 64'(m_busy && m_wr));
      chk("pmem_address", 64'(pmem_address), 64'(m_addr));
      chk("pmem_wdata", pmem_wdata, m_wdata);
      chk("req_resp", 64'(req_resp), 64'(exp_resp));
      chk("req_rdata", req_rdata, pmem_rdata);
      for (int i = 0; i < N; i++) begin
`ifdef ARB_PERF_CNT_EN
         chk("perf_grants", 64'(perf_grants[i*32 +: 32]), sat(m_gcnt[i]));
`else
         chk("perf_grants", 64'(perf_grants[i*32 +: 32]), 64'd0);
`endif
      end
`ifdef ARB_PERF_CNT_EN
      chk("perf_wait", 64'(perf_wait_cycles), sat(m_wait));
`else
      chk("perf_wait", 64'(perf_wait_cycles), 64'd0);
`endif
   endtask

   task automatic model_advance();
      int  choose;
      int  cur;
      bit  any_wait;
      choose = pick();
      cur    = -1;
      if (m_busy) cur = m_port;
      else if (!m_done) cur = choose;
      any_wait = 0;
      for (int i = 0; i < N; i++) begin
         if ((req_read[i] || req_write[i]) && i != cur) any_wait = 1;
      end
      if (any_wait) m_wait++;
      if (m_busy) begin
         if (pmem_resp) begin
            m_busy = 0;
            m_done = 1;
            m_ptr  = (m_port + 1) % N;
         end
      end else if (m_done) begin
         m_done = 0;
      end else if (choose >= 0) begin
         m_busy  = 1;
         m_port  = choose;
         m_wr    = req_write[choose];
         m_addr  = req_addr[choose*AW +: AW];
         m_wdata = req_wdata[choose*LW +: LW];
         m_gcnt[choose]++;
      end
   endtask

   // inputs are set after a rising edge; checks happen on the falling edge
   task automatic step();
      @(negedge clk);
      if (rst) model_reset();
      check_outputs();
      if (!rst) model_advance();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs();
      req_read  = '0;
      req_write = '0;
   endtask

   initial begin
      rst        = 1'b1;
      req_read   = '0;
      req_write  = '0;
      req_addr   = '0;
      req_wdata  = '0;
      pmem_rdata = '0;
      pmem_resp  = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      step();
      chk("rst_pmem_read", 64'(pmem_read), 64'd0);
      chk("rst_pmem_addr", 64'(pmem_address), 64'd0);
      chk("rst_req_resp", 64'(req_resp), 64'd0);
      rst = 1'b0;

      // single read from port0, requester drops mid-transaction
      req_read[0]     = 1'b1;
      req_addr[31:0]  = 32'h100;
      step();
      req_read = '0;
      #1;
      chk("rd_pmem_read", 64'(pmem_read), 64'd1);
      chk("rd_pmem_addr", 64'(pmem_address), 64'h100);
      step();
      chk("drop_addr_kept", 64'(pmem_address), 64'h100);
      pmem_resp  = 1'b1;
      pmem_rdata = {8{8'hAA}};
      #1;
      chk("rd_req_resp", 64'(req_resp), 64'd1);
      chk("rd_req_rdata", req_rdata, {8{8'hAA}});
      step();
      pmem_resp = 1'b0;
      #1;
      chk("done_pmem_read", 64'(pmem_read), 64'd0);
      chk("done_req_resp", 64'(req_resp), 64'd0);
      step();

      // read+write together from port1 issues only the write
      req_read[1]        = 1'b1;
      req_write[1]       = 1'b1;
      req_addr[63:32]    = 32'h40;
      req_wdata[127:64]  = 64'h1234_5678_9ABC_DEF0;
      step();
      clear_reqs();
      #1;
      chk("rw_pmem_write", 64'(pmem_write), 64'd1);
      chk("rw_pmem_read", 64'(pmem_read), 64'd0);
      chk("rw_pmem_wdata", pmem_wdata, 64'h1234_5678_9ABC_DEF0);
      pmem_resp = 1'b1;
      step();
      pmem_resp = 1'b0;
      step();

      // reset mid-transaction abandons it and restarts the pointer
      req_read[0]    = 1'b1;
      req_addr[31:0] = 32'h200;
      step();
      #1;
      chk("mid_pmem_read", 64'(pmem_read), 64'd1);
      rst       = 1'b1;
      pmem_resp = 1'b1;
      #1;
      chk("rst_drop_read", 64'(pmem_read), 64'd0);
      chk("rst_no_resp", 64'(req_resp), 64'd0);
      step();
      rst             = 1'b0;
      req_read        = 4'b0011;
      req_addr[63:32] = 32'h300;
      step();
      clear_reqs();
      #1;
      chk("post_rst_grant", 64'(pmem_address), 64'h200);
      step();
      pmem_resp = 1'b0;
      step();

      // all ports requesting: fair rotation with a gap between grants
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < N; i++) begin
         req_addr[i*AW +: AW] = 32'h1000 + 32'(i * 16);
      end
      req_read = '1;
      for (int j = 0; j < 5; j++) begin
         step();
         #1;
         chk("rr_order", 64'(pmem_address), 64'(32'h1000 + 32'((j % N) * 16)));
         chk("rr_busy", 64'(pmem_read), 64'd1);
         pmem_resp = 1'b1;
         step();
         pmem_resp = 1'b0;
         #1;
         chk("rr_gap", 64'(pmem_read | pmem_write), 64'd0);
         step();
      end
      clear_reqs();
      step();

      // random traffic, occasional resets
      for (int c = 0; c < 2000; c++) begin
         rst        = ($urandom_range(0, 199) == 0);
         req_read   = N'($urandom);
         req_write  = N'($urandom) & N'($urandom);
         req_addr   = {$urandom, $urandom, $urandom, $urandom};
         for (int i = 0; i < N; i++) begin
            req_wdata[i*LW +: LW] = {$urandom, $urandom};
         end
         if ($urandom_range(0, 2) == 0) clear_reqs();
         pmem_resp  = ($urandom_range(0, 3) == 0);
         pmem_rdata = {$urandom, $urandom};
         step();
      end
      rst = 1'b0;
      clear_reqs();
      pmem_resp = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter_n.md
MEM_ARBITER_N -- requirements
Module: mem_arbiter_n

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2: number of requesters, legal range 2..8.
REQ-002 SHALL have parameter LINE_WIDTH, default 256: cache-line data width in bits.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32: address width in bits.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port req_read, input, NUM_PORTS bits: per-port line-read request.
REQ-007 SHALL have port req_write, input, NUM_PORTS bits: per-port line-write request.
REQ-008 SHALL have port req_addr, input, NUM_PORTS*ADDR_WIDTH bits: packed addresses; port i occupies slice i.
REQ-009 SHALL have port req_wdata, input, NUM_PORTS*LINE_WIDTH bits: packed write lines; port i occupies slice i.
REQ-010 SHALL have port req_rdata, output, LINE_WIDTH bits: read line, broadcast to all ports.
REQ-011 SHALL have port req_resp, output, NUM_PORTS bits: one-hot completion pulse.
REQ-012 SHALL have ports pmem_read and pmem_write, output, 1 bit each: downstream request.
REQ-013 SHALL have port pmem_address, output, ADDR_WIDTH bits: downstream address.
REQ-014 SHALL have port pmem_wdata, output, LINE_WIDTH bits: downstream write line.
REQ-015 SHALL have port pmem_rdata, input, LINE_WIDTH bits: downstream read line.
REQ-016 SHALL have port pmem_resp, input, 1 bit: downstream completion.
REQ-017 SHALL have port perf_grants, output, NUM_PORTS*32 bits: per-port grant counters.
REQ-018 SHALL have port perf_wait_cycles, output, 32 bits: cycles spent with an ungranted request pending.

Function
REQ-019 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-020 In IDLE with any (req_read|req_write) bit set, SHALL select the first active port scanning upward from rr_ptr with wrap at NUM_PORTS-1 to 0, then go to BUSY.
REQ-021 On the IDLE->BUSY edge SHALL latch the granted index, operation, address and wdata; pmem_* SHALL be driven only from these latches.
REQ-022 pmem_read or pmem_write SHALL assert in the first BUSY cycle (one cycle after the request is sampled) and hold until pmem_resp.
REQ-023 If a port asserts both read and write, SHALL issue the write only and drop the read.
REQ-024 In BUSY with pmem_resp=1, SHALL pulse req_resp[granted] combinationally in that same cycle, pass pmem_rdata to req_rdata, and go to DONE.
REQ-025 DONE SHALL last exactly one cycle with pmem_read/pmem_write low and no grant made, then go to IDLE.
REQ-026 On leaving BUSY, rr_ptr SHALL become (granted+1) modulo NUM_PORTS.
REQ-027 A requester that deasserts mid-BUSY SHALL NOT abort the transaction; it SHALL still complete and still receive its req_resp pulse.
REQ-028 req_resp SHALL be all-zero outside the BUSY&pmem_resp cycle; at most one bit SHALL be set at any time.
REQ-029 req_rdata SHALL equal pmem_rdata at all times.

Reset
REQ-030 While rst=1, SHALL force FSM=IDLE, rr_ptr=0, latches=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, req_resp=0, and all perf counters=0, asynchronously.
REQ-031 A reset during BUSY SHALL abandon the transaction without a req_resp pulse; a pmem_resp arriving after reset release while in IDLE SHALL be ignored.

Configuration
REQ-032 With macro ARB_PERF_CNT_EN defined, perf_grants[i] SHALL increment on each grant to port i and perf_wait_cycles SHALL increment each cycle in which any request is not the current grant; both SHALL saturate at 32'hFFFF_FFFF.
REQ-033 Without ARB_PERF_CNT_EN, the perf ports SHALL still exist, tied to zero, with no counter flops.

Verification
REQ-034 NUM_PORTS=2; port0 read at addr 0x100 from IDLE -> pmem_read=1 and pmem_address=0x100 on the next cycle; pmem_resp with rdata=0xAA..AA -> req_resp=2'b01, req_rdata=0xAA..AA in the same cycle.
REQ-035 NUM_PORTS=4; all ports hold requests continuously -> grant order 0,1,2,3,0 with one DONE cycle between consecutive grants.
REQ-036 Port1 asserts read and write together at 0x40 -> only pmem_write=1, with pmem_wdata equal to the port1 slice.
REQ-037 Port0 granted, then rst pulses mid-BUSY -> pmem_read=0 immediately, no req_resp pulse, rr_ptr=0, next grant made from IDLE.
REQ-038 ARB_PERF_CNT_EN defined; 3 grants to port0 and port1 waiting 5 cycles -> perf_grants[0]=3, perf_wait_cycles=5. With the macro undefined -> both read 0.
REQ-039 Port0 drops its request mid-BUSY -> pmem address is unchanged; on pmem_resp, req_resp[0] pulses once.
